// File: rtl/layer_tm.sv
// layer_tm: time-multiplexed fully-connected layer; NN neurons on LANES shared MAC lanes.
// Latency: first o_valid NUM_WEIGHT+3 cycles after the last sample; each pass NUM_WEIGHT+2+LANES cycles.
// Backpressure: none on o_valid; x_ready is low (x_valid ignored) whenever the block is busy.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   weightValid/weightValue  weight write (shared auto-incrementing tap pointer per neuron)
//   biasValid/biasValue      bias write
//   config_layer_num/_neuron_num  load target; loads apply only in IDLE to this layer, neuron < NN
//   x_valid/x_in/x_ready     input frame, NUM_WEIGHT samples
//   o_valid/o_data/o_index   serial results with neuron number
//   busy, done               not-IDLE flag, end-of-frame pulse
// Build option: define LAYER_TM_RELU_EN to clamp negative results to 0 (default: identity).
// Assumes NN >= 2 and WEIGHT_INT_WIDTH < DATA_WIDTH.
module layer_tm #(
  parameter int NN               = 10,
  parameter int NUM_WEIGHT       = 30,
  parameter int DATA_WIDTH       = 16,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int LANES            = 2,
  parameter int LAYER_NUM        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    weightValid,
  input  logic                    biasValid,
  input  logic [31:0]             weightValue,
  input  logic [31:0]             biasValue,
  input  logic [31:0]             config_layer_num,
  input  logic [31:0]             config_neuron_num,
  input  logic                    x_valid,
  input  logic [DATA_WIDTH-1:0]   x_in,
  output logic                    x_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [$clog2(NN)-1:0]   o_index,
  output logic                    busy,
  output logic                    done
);

  localparam int DW    = DATA_WIDTH;
  localparam int F     = DATA_WIDTH - WEIGHT_INT_WIDTH;
  localparam int AW    = 2*DATA_WIDTH + $clog2(NUM_WEIGHT) + 1;
  localparam int NPASS = (NN + LANES - 1) / LANES;
  localparam int NIW   = $clog2(NN);
  localparam int KW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int PSW   = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  // wide enough for every lane slot index, including the unused ones past NN-1
  localparam int NBW   = $clog2(NPASS*LANES + 1);

  localparam logic [KW-1:0]  K_LAST = KW'(NUM_WEIGHT - 1);
  localparam logic [PSW-1:0] P_LAST = PSW'(NPASS - 1);
  localparam logic [LW-1:0]  L_LAST = LW'(LANES - 1);
  localparam logic [NBW-1:0] NN_N   = NBW'(NN);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPUTE, S_DRAIN, S_BIAS, S_OUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // parameter and frame storage; deliberately not reset so loads survive rst
  logic [DW-1:0] wmem [NN][NUM_WEIGHT];
  logic [DW-1:0] bmem [NN];
  logic [DW-1:0] xbuf [NUM_WEIGHT];

  logic [KW-1:0]  icnt, kcnt, wptr;
  logic [PSW-1:0] pass;
  logic [LW-1:0]  lcnt;
  logic [NIW-1:0] last_wn;
  logic           mac_vld, mac_first;

  logic [DW-1:0]        x_r;
  logic [DW-1:0]        w_r   [LANES];
  logic [DW-1:0]        b_r   [LANES];
  logic signed [AW-1:0] acc   [LANES];

  logic [NBW-1:0]       lane_full [LANES];
  logic [NIW-1:0]       lane_n    [LANES];
  logic                 lane_ok   [LANES];

  // ---------------- config load decode ----------------
  logic           cfg_hit, w_we, b_we, x_we;
  logic [NIW-1:0] cfg_n;
  logic [KW-1:0]  w_col;
  logic           unused_cfg;

  assign cfg_hit = (state == S_IDLE) && (config_layer_num == 32'(LAYER_NUM))
                   && (config_neuron_num < 32'(NN));
  assign cfg_n   = config_neuron_num[NIW-1:0];
  assign w_we    = weightValid && cfg_hit;
  assign b_we    = biasValid && cfg_hit;
  assign x_we    = (state == S_IDLE) && x_valid;
  // a write to a different neuron than the last accepted one restarts at tap 0
  assign w_col   = (cfg_n != last_wn) ? '0 : wptr;
  assign unused_cfg = ^{weightValue[31:DW], biasValue[31:DW]};

  // ---------------- lane slot indices for the current pass ----------------
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_full[l] = NBW'(pass) * NBW'(LANES) + NBW'(l);
      lane_ok[l]   = lane_full[l] < NN_N;
      lane_n[l]    = lane_full[l][NIW-1:0];
    end
  end

  // ---------------- FSM state and counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      icnt      <= '0;
      kcnt      <= '0;
      pass      <= '0;
      lcnt      <= '0;
      wptr      <= '0;
      last_wn   <= '0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      // product of cycle k is formed one cycle later from the registered reads
      mac_vld   <= (state == S_COMPUTE);
      mac_first <= (state == S_COMPUTE) && (kcnt == '0);
      if (w_we) begin
        last_wn <= cfg_n;
        wptr    <= (w_col == K_LAST) ? '0 : w_col + KW'(1);
      end
      case (state)
        S_IDLE: begin
          if (x_valid) begin
            icnt <= (icnt == K_LAST) ? '0 : icnt + KW'(1);
            if (icnt == K_LAST) begin
              pass <= '0;
              kcnt <= '0;
            end
          end
        end
        S_COMPUTE: kcnt <= (kcnt == K_LAST) ? '0 : kcnt + KW'(1);
        S_BIAS:    lcnt <= '0;
        S_OUT: begin
          if (lcnt == L_LAST) begin
            lcnt <= '0;
            if (pass != P_LAST) pass <= pass + PSW'(1);
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        S_DONE:    icnt <= '0;
        default:   ;
      endcase
    end
  end

  // ---------------- memories, registered reads, MAC lanes ----------------
  logic signed [2*DW-1:0] prod   [LANES];
  logic signed [AW-1:0]   prod_x [LANES];
  logic signed [AW-1:0]   bias_x [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l]   = $signed(x_r) * $signed(w_r[l]);
      prod_x[l] = {{(AW-2*DW){prod[l][2*DW-1]}}, prod[l]};
      bias_x[l] = {{(AW-DW-F){b_r[l][DW-1]}}, b_r[l], {F{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) wmem[cfg_n][w_col] <= weightValue[DW-1:0];
    if (b_we) bmem[cfg_n]        <= biasValue[DW-1:0];
    if (x_we) xbuf[icnt]         <= x_in;
    if (state == S_COMPUTE) begin
      x_r <= xbuf[kcnt];
      for (int l = 0; l < LANES; l++)
        w_r[l] <= lane_ok[l] ? wmem[lane_n[l]][kcnt] : '0;
    end
    if (state == S_DRAIN) begin
      for (int l = 0; l < LANES; l++)
        b_r[l] <= lane_ok[l] ? bmem[lane_n[l]] : '0;
    end
    for (int l = 0; l < LANES; l++) begin
      if (mac_vld)
        acc[l] <= mac_first ? prod_x[l] : acc[l] + prod_x[l];
      else if (state == S_BIAS)
        acc[l] <= acc[l] + bias_x[l];
    end
  end

  // ---------------- result: scale, saturate, activate ----------------
  logic signed [AW-1:0] acc_sel, acc_sh;
  logic                 in_range;
  logic [DW-1:0]        sat, act;

  always_comb begin
    acc_sel  = acc[lcnt];
    acc_sh   = acc_sel >>> F;
    // fits in DW bits only if every bit above the DW-bit sign matches it
    in_range = (acc_sh[AW-1:DW-1] == {(AW-DW+1){acc_sh[DW-1]}});
    if (in_range)
      sat = acc_sh[DW-1:0];
    else if (acc_sh[AW-1])
      sat = {1'b1, {(DW-1){1'b0}}};
    else
      sat = {1'b0, {(DW-1){1'b1}}};
`ifdef LAYER_TM_RELU_EN
    act = sat[DW-1] ? '0 : sat;
`else
    act = sat;
`endif
  end

  // ---------------- next state and outputs ----------------
  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    o_valid   = 1'b0;
    o_data    = '0;
    o_index   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        x_ready = 1'b1;
        busy    = 1'b0;
        if (x_valid && (icnt == K_LAST)) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: if (kcnt == K_LAST) state_nxt = S_DRAIN;
      S_DRAIN:   state_nxt = S_BIAS;
      S_BIAS:    state_nxt = S_OUT;
      S_OUT: begin
        // slots past the last neuron still take their cycle, silently
        if (lane_ok[lcnt]) begin
          o_valid = 1'b1;
          o_data  = act;
          o_index = lane_n[lcnt];
        end
        if (lcnt == L_LAST) state_nxt = (pass == P_LAST) ? S_DONE : S_COMPUTE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_tm.sv
// Directed bench for layer_tm with NN=3, NUM_WEIGHT=4, LANES=2, Q4.12 data (1.0 = 0x1000).
module tb_layer_tm;

  localparam int NN = 3;
  localparam int NW = 4;
  localparam int DW = 16;

`ifdef LAYER_TM_RELU_EN
  localparam logic [15:0] NEG_ONE4 = 16'h0000;
  localparam logic [15:0] SAT_NEG  = 16'h0000;
  localparam logic [15:0] BIAS_NEG = 16'h0000;
`else
  localparam logic [15:0] NEG_ONE4 = 16'hC000;
  localparam logic [15:0] SAT_NEG  = 16'h8000;
  localparam logic [15:0] BIAS_NEG = 16'hE000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          weightValid = 1'b0, biasValid = 1'b0;
  logic [31:0]   weightValue = '0, biasValue = '0;
  logic [31:0]   config_layer_num = '0, config_neuron_num = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic          x_ready, o_valid, busy, done;
  logic [DW-1:0] o_data;
  logic [1:0]    o_index;

  layer_tm #(
    .NN(NN), .NUM_WEIGHT(NW), .DATA_WIDTH(DW), .WEIGHT_INT_WIDTH(4),
    .LANES(2), .LAYER_NUM(3)
  ) dut (
    .clk(clk), .rst(rst),
    .weightValid(weightValid), .biasValid(biasValid),
    .weightValue(weightValue), .biasValue(biasValue),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .x_valid(x_valid), .x_in(x_in), .x_ready(x_ready),
    .o_valid(o_valid), .o_data(o_data), .o_index(o_index),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // captured results of the latest frame
  int nout, ndone, first_n, done_n;
  int r_idx [8];
  int r_dat [8];
  int r_n   [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int layer, input int neuron, input logic [15:0] v);
    weightValid       = 1'b1;
    config_layer_num  = layer;
    config_neuron_num = neuron;
    weightValue       = {16'h0000, v};
    tick;
    weightValid       = 1'b0;
  endtask

  task automatic load_b(input int layer, input int neuron, input logic [15:0] v);
    biasValid         = 1'b1;
    config_layer_num  = layer;
    config_neuron_num = neuron;
    biasValue         = {16'h0000, v};
    tick;
    biasValid         = 1'b0;
  endtask

  task automatic load_neuron(input int neuron, input logic [15:0] v);
    for (int k = 0; k < NW; k++) load_w(3, neuron, v);
  endtask

  task automatic load_basic;
    load_neuron(0, 16'h1000);
    load_neuron(1, 16'h0800);
    load_neuron(2, 16'hF000);
    for (int n = 0; n < NN; n++) load_b(3, n, 16'h0000);
  endtask

  // Sends one frame, then watches 20 cycles; n=1 is the cycle after the last accept.
  // With inject set, a matching weight+bias write is attempted mid-frame.
  task automatic run_frame(input logic [15:0] x0, input logic [15:0] x1,
                           input logic [15:0] x2, input logic [15:0] x3, input bit inject);
    logic [15:0] xs [4];
    xs = '{x0, x1, x2, x3};
    nout = 0; ndone = 0; first_n = -1; done_n = -1;
    for (int i = 0; i < 8; i++) begin r_idx[i] = -1; r_dat[i] = -1; r_n[i] = -1; end
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x_in    = xs[i];
      tick;
    end
    x_valid = 1'b0;
    x_in    = '0;
    for (int n = 1; n <= 20; n++) begin
      if (inject && n == 3) begin
        weightValid = 1'b1; biasValid = 1'b1;
        config_layer_num = 3; config_neuron_num = 0;
        weightValue = 32'h7FFF; biasValue = 32'h7FFF;
      end else begin
        weightValid = 1'b0; biasValid = 1'b0;
      end
      if (o_valid) begin
        if (first_n < 0) first_n = n;
        if (nout < 8) begin
          r_idx[nout] = int'(o_index);
          r_dat[nout] = int'(o_data);
          r_n[nout]   = n;
        end
        nout++;
      end
      if (done) begin
        ndone++;
        done_n = n;
      end
      tick;
    end
  endtask

  task automatic check3(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2);
    chk({tag, " count"}, nout, 3);
    chk({tag, " idx0"}, r_idx[0], 0);
    chk({tag, " idx1"}, r_idx[1], 1);
    chk({tag, " idx2"}, r_idx[2], 2);
    chk({tag, " dat0"}, r_dat[0], {16'h0, e0});
    chk({tag, " dat1"}, r_dat[1], {16'h0, e1});
    chk({tag, " dat2"}, r_dat[2], {16'h0, e2});
    chk({tag, " done_cnt"}, ndone, 1);
  endtask

  task automatic check_basic(input string tag);
    check3(tag, 16'h4000, 16'h2000, NEG_ONE4);
    chk({tag, " first_lat"}, first_n, 7);
    chk({tag, " lat1"}, r_n[1], 8);
    chk({tag, " lat2"}, r_n[2], 15);
    chk({tag, " done_at"}, done_n, 17);
  endtask

  int acc_cnt, fifth_t, o2_t, hs_err, quiet;

  initial begin
    // ---- reset state ----
    tick;
    chk("rst o_valid", o_valid, 0);
    chk("rst o_data", o_data, 0);
    chk("rst o_index", o_index, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst x_ready", x_ready, 1);
    rst = 1'b1;
    tick;

    // ---- basic MAC ----
    load_basic;
    run_frame(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    check_basic("basic");

    // ---- load filter: wrong layer, out-of-range neuron, write while busy ----
    load_w(2, 0, 16'h7FFF);
    load_w(3, 5, 16'h7FFF);
    load_b(2, 1, 16'h7FFF);
    load_b(3, 5, 16'h7FFF);
    run_frame(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    check_basic("filter_a");
    run_frame(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    check_basic("filter_b");

    // ---- saturation ----
    for (int n = 0; n < NN; n++) load_neuron(n, 16'h7FFF);
    run_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    check3("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int n = 0; n < NN; n++) load_neuron(n, 16'h8000);
    run_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    check3("sat_neg", SAT_NEG, SAT_NEG, SAT_NEG);

    // ---- bias only (zero inputs) ----
    load_b(3, 0, 16'hE000);
    load_b(3, 1, 16'h1800);
    load_b(3, 2, 16'h0000);
    run_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check3("bias", BIAS_NEG, 16'h1800, 16'h0000);

    // ---- handshake: x_valid held high across two frames ----
    load_basic;
    x_valid = 1'b1; x_in = 16'h1000;
    acc_cnt = 0; fifth_t = -1; o2_t = -1; hs_err = 0; nout = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin r_idx[i] = -1; r_dat[i] = -1; end
    for (int t = 0; t < 60; t++) begin
      if (x_ready !== !busy) hs_err++;
      if (x_valid && x_ready) begin
        acc_cnt++;
        if (acc_cnt == 5) fifth_t = t;
      end
      if (o_valid) begin
        if (nout == 3) o2_t = t;
        if (nout < 8) begin r_idx[nout] = int'(o_index); r_dat[nout] = int'(o_data); end
        nout++;
      end
      if (done) begin
        ndone++;
        if (ndone == 2) x_valid = 1'b0;
      end
      tick;
      if (ndone == 2) break;
    end
    x_valid = 1'b0;
    chk("hs accepts", acc_cnt, 8);
    chk("hs restart_t", fifth_t, 21);
    chk("hs ready_vs_busy", hs_err, 0);
    chk("hs done_cnt", ndone, 2);
    chk("hs outputs", nout, 6);
    chk("hs frame2_lat", o2_t, 31);
    chk("hs f2 idx2", r_idx[5], 2);
    chk("hs f2 dat0", r_dat[3], 32'h4000);
    chk("hs f2 dat2", r_dat[5], {16'h0, NEG_ONE4});
    chk("hs idle_after", busy, 0);

    // ---- reset in the middle of COMPUTE ----
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1; x_in = 16'h1000;
      tick;
    end
    x_valid = 1'b0;
    tick;
    tick;
    chk("pre_rst busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst o_valid", o_valid, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst x_ready", x_ready, 1);
    tick;
    rst = 1'b1;
    quiet = 0;
    for (int n = 0; n < 20; n++) begin
      if (o_valid || done) quiet++;
      tick;
    end
    chk("post_rst silent", quiet, 0);
    run_frame(16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    check_basic("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_tm.md
Name: layer_tm

Overview:
- Parametrised, time-multiplexed fully-connected layer.
- It is the successor to the fixed, fully-unrolled per-neuron layer.
- It computes NN neurons using LANES shared MAC lanes, over ceil(NN/LANES) passes.
- It buffers one input frame and emits the results serially with a neuron index. Weights and biases are loaded over the existing config bus.

Parameters:
- NN, 10: neurons in the layer.
- NUM_WEIGHT, 30: inputs per neuron (frame length).
- DATA_WIDTH, 16: signed fixed-point width of data, weights and outputs.
- WEIGHT_INT_WIDTH, 4: integer bits. Fraction bits are F = DATA_WIDTH - WEIGHT_INT_WIDTH.
- LANES, 2: parallel MAC lanes (1..NN).
- LAYER_NUM, 3: layer id matched against config_layer_num.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- weightValid  in  1  weight write strobe.
- biasValid  in  1  bias write strobe.
- weightValue  in  32  weight; uses bits [DATA_WIDTH-1:0].
- biasValue  in  32  bias; uses bits [DATA_WIDTH-1:0].
- config_layer_num  in  32  target layer of a load.
- config_neuron_num  in  32  target neuron of a load.
- x_valid  in  1  input sample strobe.
- x_in  in  DATA_WIDTH  input sample.
- x_ready  out  1  high when the block accepts x_valid.
- o_valid  out  1  output result strobe.
- o_data  out  DATA_WIDTH  neuron result.
- o_index  out  $clog2(NN)  neuron number of o_data.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last result of a frame.

Behaviour:
- Reset: clocking and reset are fixed as one clock (clk) and an asynchronous, active-low reset (rst).
  - While rst is low, the state is IDLE and all counters are 0.
  - o_valid, o_data, o_index, busy and done are 0; x_ready is 1.
  - Weight, bias and input memories are not cleared. Loaded parameters survive reset.
- Loads (accepted only in IDLE):
  - A load applies only when config_layer_num == LAYER_NUM and config_neuron_num < NN.
  - Weights: a shared write pointer wptr writes w[config_neuron_num][wptr] and then increments, wrapping to 0 at NUM_WEIGHT.
  - wptr resets to 0 when config_neuron_num differs from the neuron of the previous accepted weight write.
  - Bias: biasValid writes b[config_neuron_num].
  - Loads that do not match, or that arrive while busy, are silently dropped.
- State machine: IDLE -> COMPUTE -> DRAIN -> BIAS -> OUT -> (COMPUTE for the next pass | DONE) -> IDLE.
  - IDLE: x_ready=1. Each x_valid writes x_in to xbuf[icnt] and increments icnt. When the NUM_WEIGHT-th sample is accepted, go to COMPUTE with pass=0.
  - COMPUTE, NUM_WEIGHT cycles: cycle k issues xbuf[k] and w[pass*LANES+l][k] to each lane l. Memory read is registered, 1 cycle.
  - Lane accumulators are cleared on the first product.
  - DRAIN: 1 cycle, accumulates the final product.
  - BIAS: 1 cycle. acc += sign_extend(b) << F.
  - OUT: LANES cycles, one per lane. Lane l emits o_valid=1, o_index=pass*LANES+l, o_data=result.
  - Lanes whose index is >= NN are skipped: o_valid stays 0 and the cycle is still spent.
  - DONE: 1 cycle with done=1, then IDLE with icnt=0.
- Arithmetic:
  - Product is 2*DATA_WIDTH bits signed.
  - Accumulator is 2*DATA_WIDTH + $clog2(NUM_WEIGHT) + 1 bits signed; it never wraps.
  - Result = acc >>> F (arithmetic shift), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then the activation (see the optional feature).
- Latency:
  - The first o_valid of a frame is high NUM_WEIGHT+3 cycles after the cycle that accepted the last sample.
  - Each pass lasts NUM_WEIGHT+2+LANES cycles.
- Flow control: o_valid has no backpressure. While busy, x_ready=0 and x_valid is ignored.
- Reset mid-frame: the frame is abandoned and no further o_valid or done occurs. The next frame needs no reload of parameters.

Optional Feature:
- Macro: LAYER_TM_RELU_EN.
- Defined: negative saturated results output as 0; positive results pass unchanged.
- Undefined: identity activation; the signed saturated result is output.

Test Plan:
- Setup: NN=3, NUM_WEIGHT=4, LANES=2, DATA_WIDTH=16, WEIGHT_INT_WIDTH=4, so 1.0 = 0x1000.
- Basic MAC: load w0=0x1000, w1=0x0800, w2=0xF000 (all four taps) and all biases 0; input 0x1000 x4 -> outputs (index, data) (0,0x4000), (1,0x2000), then (2,0x0000) with RELU_EN or (2,0xC000) without. First o_valid comes 7 cycles after the last accept. The pass-1 lane 1 slot is silent. done pulses once.
- Saturation: all weights 0x7FFF, inputs 0x7FFF -> o_data=0x7FFF for every neuron. Without RELU_EN, weights 0x8000 with inputs 0x7FFF -> o_data=0x8000.
- Bias: bias b1=0x1800 with all-zero inputs -> index 1 gives 0x1800. Bias 0xE000 -> 0x0000 with RELU_EN, 0xE000 without.
- Load filter: weightValid with config_layer_num=2, or with config_neuron_num=5, or while busy -> a rerun of the basic frame gives identical results.
- Handshake: x_valid held high through the whole frame -> only 4 samples are accepted, x_ready=0 until DONE, and the next frame starts on the cycle after the IDLE return.
- Reset mid-COMPUTE: pulse rst low for 1 cycle -> o_valid=0, busy=0, x_ready=1 immediately. A new frame without reload gives the basic-MAC results.
